// File: rtl/column_window_feeder_pkg.sv
// Shared defaults for the raster-to-column front end and the 7x7 median filter.
//   DEF_DATA_WIDTH  pixel width in bits
//   DEF_COLUMN_NUM  window height in rows; the feeder keeps DEF_COLUMN_NUM-1 line buffers
//   DEF_IMG_WIDTH   pixels per line
//   DEF_IMG_HEIGHT  lines per frame
//   DEF_ADDR_W      x-counter / line RAM address width, >= clog2(DEF_IMG_WIDTH)
// rot_idx() maps a position relative to the oldest line buffer onto a
// physical buffer index, wrapping modulo the buffer count.
package column_window_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_COLUMN_NUM = 7;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_ADDR_W     = 10;

  function automatic int rot_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/column_window_feeder_line.sv
// One buffered image line: single port, one write and one read at the same
// address per cycle, synchronous read-first (a simultaneous write returns the
// previous contents). The storage array has no reset.
//   clk    clock
//   we     write enable
//   addr   pixel x position
//   wdata  pixel to store
//   rdata  registered read data (value before this cycle's write)
module line_ram
  import column_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_IMG_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/column_window_feeder.sv
// Raster-to-column front end for the 7x7 median filter. Takes one raster
// pixel per valid cycle, keeps the previous COLUMN_NUM-1 lines in rotating
// line RAMs and emits one vertical column per accepted pixel, two cycles later.
//   clk          clock
//   rst          asynchronous active-low reset
//   pix_in       raster pixel
//   pix_valid    pix_in accepted this cycle
//   frame_start  with pix_valid: this pixel is (0,0)
//   out0..out6   column, out0 = row y-6 (oldest) ... out6 = row y
//   col_valid    out0..out6 hold a complete column
//   refresh      pulse one cycle before each emitted line's first column
//   frame_done   pulse with the column of the frame's last pixel
module column_window_feeder
  import column_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COLUMN_NUM = DEF_COLUMN_NUM,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic                  col_valid,
  output logic                  refresh,
  output logic                  frame_done
);

  localparam int NBUF  = COLUMN_NUM - 1;
  localparam int Y_W   = $clog2(IMG_HEIGHT);
  localparam int ROW_W = (NBUF > 1) ? $clog2(NBUF) : 1;

  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(IMG_HEIGHT - 1);
  localparam logic [Y_W-1:0]    Y_FIRST  = Y_W'(COLUMN_NUM - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NBUF - 1);

  // position of the next pixel and the oldest line buffer
  logic [ADDR_W-1:0] x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic [ROW_W-1:0]  wr_row;

  logic [ADDR_W-1:0] x_p0;
  logic [Y_W-1:0]    y_p0;
  logic [ROW_W-1:0]  row_p0;

  logic [DATA_WIDTH-1:0] ram_rd [NBUF];

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] pix_p1;
  logic [ADDR_W-1:0]     x_p1;
  logic [Y_W-1:0]        y_p1;
  logic [ROW_W-1:0]      row_p1;
  logic [DATA_WIDTH-1:0] col_sel [NBUF];

  logic [DATA_WIDTH-1:0] out_p2 [COLUMN_NUM];

  // ---- stage 0: coordinates of the accepted pixel ----
  // frame_start overrides the running counters, even mid-frame.
  always_comb begin
    x_p0   = x_cnt;
    y_p0   = y_cnt;
    row_p0 = wr_row;
    if (frame_start) begin
      x_p0   = '0;
      y_p0   = '0;
      row_p0 = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      wr_row <= '0;
    end else if (pix_valid) begin
      if (x_p0 == X_LAST) begin
        x_cnt  <= '0;
        y_cnt  <= (y_p0 == Y_LAST) ? '0 : y_p0 + 1'b1;
        wr_row <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        x_cnt  <= x_p0 + 1'b1;
        y_cnt  <= y_p0;
        wr_row <= row_p0;
      end
    end
  end

  // The oldest buffer receives the new pixel while returning the line that
  // it replaces, so every buffer is read at x in the same cycle.
  for (genvar k = 0; k < NBUF; k++) begin : g_line
    line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_W     (ADDR_W)
    ) u_line (
      .clk   (clk),
      .we    (pix_valid && (row_p0 == ROW_W'(k))),
      .addr  (x_p0),
      .wdata (pix_in),
      .rdata (ram_rd[k])
    );
  end

  // ---- stage 1: RAM read data and delayed pixel/coordinates ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= pix_valid;
  end

  always_ff @(posedge clk) begin
    pix_p1 <= pix_in;
    x_p1   <= x_p0;
    y_p1   <= y_p0;
    row_p1 <= row_p0;
  end

  // Buffer row_p1 holds row y-6; the others follow in ring order up to y-1.
  always_comb begin
    for (int j = 0; j < NBUF; j++) begin
      col_sel[j] = '0;
      for (int k = 0; k < NBUF; k++) begin
        if (rot_idx(int'(row_p1), j, NBUF) == k) col_sel[j] = ram_rd[k];
      end
    end
  end

  // Lead the line's x=0 column by one cycle; the filter flushes its queue here.
  assign refresh = vld_p1 && (x_p1 == '0) && (y_p1 >= Y_FIRST);

  // ---- stage 2: registered column and flags ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int j = 0; j < COLUMN_NUM; j++) out_p2[j] <= '0;
    end else begin
      col_valid  <= vld_p1 && (y_p1 >= Y_FIRST);
      frame_done <= vld_p1 && (y_p1 >= Y_FIRST) && (x_p1 == X_LAST) && (y_p1 == Y_LAST);
      // bubbles leave the last column on the outputs
      if (vld_p1) begin
        for (int j = 0; j < NBUF; j++) out_p2[j] <= col_sel[j];
        out_p2[NBUF] <= pix_p1;
      end
    end
  end

  assign out0 = out_p2[0];
  assign out1 = out_p2[1];
  assign out2 = out_p2[2];
  assign out3 = out_p2[3];
  assign out4 = out_p2[4];
  assign out5 = out_p2[5];
  assign out6 = out_p2[6];

endmodule

// File: tb/tb_column_window_feeder.sv
// Directed bench for column_window_feeder on an 8x8 image.
// Frame pattern A: pixel = 16*y + x. Frame pattern B: pixel = 0xF0 - (16*y + x).
module tb_column_window_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6;
  logic       col_valid, refresh, frame_done;
  logic [7:0] outs [7];

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int rf_cnt = 0;
  int fd_cnt = 0;
  int cv_base;

  always #5 clk = ~clk;

  column_window_feeder #(
    .DATA_WIDTH (8),
    .COLUMN_NUM (7),
    .IMG_WIDTH  (8),
    .IMG_HEIGHT (8),
    .ADDR_W     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out4        (out4),
    .out5        (out5),
    .out6        (out6),
    .col_valid   (col_valid),
    .refresh     (refresh),
    .frame_done  (frame_done)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;

  // pulse counters, sampled mid-cycle while out of reset
  always @(negedge clk) begin
    if (rst) begin
      cv_cnt = cv_cnt + int'(col_valid);
      rf_cnt = rf_cnt + int'(refresh);
      fd_cnt = fd_cnt + int'(frame_done);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pv(input int x, input int y, input bit b);
    return b ? (240 - (16 * y + x)) : (16 * y + x);
  endfunction

  task automatic px(input int x, input int y, input bit fs, input bit b);
    pix_in      = 8'(pv(x, y, b));
    pix_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic bub();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rows(input int y0, input int y1, input bit b);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 8; x++) px(x, y, 1'b0, b);
  endtask

  task automatic chk_col(input string tag, input int x, input int y, input bit b);
    for (int r = 0; r < 7; r++)
      check($sformatf("%s_out%0d", tag, r), int'(outs[r]), pv(x, y - 6 + r, b));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_cv"}, int'(col_valid), 0);
    check({tag, "_rf"}, int'(refresh), 0);
    check({tag, "_fd"}, int'(frame_done), 0);
    for (int r = 0; r < 7; r++)
      check($sformatf("%s_out%0d", tag, r), int'(outs[r]), 0);
  endtask

  initial begin
    rst = 1'b0; pix_in = '0; pix_valid = 1'b0; frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    repeat (4) bub();
    check("idle_cv", cv_cnt, 0);
    check("idle_rf", rf_cnt, 0);
    check("idle_fd", fd_cnt, 0);

    // frame A, rows 0..5 buffer only
    px(0, 0, 1'b1, 1'b0);
    for (int x = 1; x < 8; x++) px(x, 0, 1'b0, 1'b0);
    rows(1, 5, 1'b0);
    px(0, 6, 1'b0, 1'b0);
    check("a_rows0_5_cv", cv_cnt, 0);
    check("a_r6_refresh", int'(refresh), 1);
    check("a_r6_cv_early", int'(col_valid), 0);
    // valid pattern 1,0,0,1 in row 6
    bub();
    check("a_r6x0_cv", int'(col_valid), 1);
    check("a_r6x0_rf", int'(refresh), 0);
    chk_col("a_r6x0", 0, 6, 1'b0);
    bub();
    check("a_gap1_cv", int'(col_valid), 0);
    chk_col("a_hold", 0, 6, 1'b0);
    px(1, 6, 1'b0, 1'b0);
    check("a_gap2_cv", int'(col_valid), 0);
    check("a_gap2_out0", int'(out0), 8'h00);
    px(2, 6, 1'b0, 1'b0);
    check("a_r6x1_cv", int'(col_valid), 1);
    chk_col("a_r6x1", 1, 6, 1'b0);
    for (int x = 3; x < 8; x++) px(x, 6, 1'b0, 1'b0);
    for (int x = 0; x < 4; x++) px(x, 7, 1'b0, 1'b0);
    px(4, 7, 1'b0, 1'b0);
    chk_col("a_r7x3", 3, 7, 1'b0);
    px(5, 7, 1'b0, 1'b0);
    px(6, 7, 1'b0, 1'b0);
    px(7, 7, 1'b0, 1'b0);
    check("a_fd_early", fd_cnt, 0);

    // frame B starts right after the last pixel of frame A
    px(0, 0, 1'b1, 1'b1);
    check("a_last_cv", int'(col_valid), 1);
    check("a_last_fd", int'(frame_done), 1);
    chk_col("a_last", 7, 7, 1'b0);
    px(1, 0, 1'b0, 1'b1);
    check("a_fd_pulse", int'(frame_done), 0);
    check("a_refresh_cnt", rf_cnt, 2);
    check("a_cv_cnt", cv_cnt, 16);
    check("a_fd_cnt", fd_cnt, 1);
    for (int x = 2; x < 8; x++) px(x, 0, 1'b0, 1'b1);
    rows(1, 5, 1'b1);
    px(0, 6, 1'b0, 1'b1);
    check("b_rows0_5_cv", cv_cnt, 16);
    check("b_r6_refresh", int'(refresh), 1);
    px(1, 6, 1'b0, 1'b1);
    check("b_r6x0_cv", int'(col_valid), 1);
    chk_col("b_r6x0", 0, 6, 1'b1);

    // frame C (pattern A) restarted mid-frame at (3,4) by frame D (pattern B)
    px(0, 0, 1'b1, 1'b0);
    px(1, 0, 1'b0, 1'b0);
    px(2, 0, 1'b0, 1'b0);
    cv_base = cv_cnt;
    for (int x = 3; x < 8; x++) px(x, 0, 1'b0, 1'b0);
    rows(1, 3, 1'b0);
    for (int x = 0; x < 3; x++) px(x, 4, 1'b0, 1'b0);
    px(0, 0, 1'b1, 1'b1);
    for (int x = 1; x < 8; x++) px(x, 0, 1'b0, 1'b1);
    rows(1, 5, 1'b1);
    px(0, 6, 1'b0, 1'b1);
    check("d_no_early_cv", cv_cnt, cv_base);
    check("d_r6_refresh", int'(refresh), 1);
    px(1, 6, 1'b0, 1'b1);
    check("d_r6x0_cv", int'(col_valid), 1);
    chk_col("d_r6x0", 0, 6, 1'b1);
    px(2, 6, 1'b0, 1'b1);
    check("d_r6x1_cv", int'(col_valid), 1);
    // asynchronous reset in the middle of a cycle
    #2 rst = 1'b0;
    #1;
    chk_zero("async_rst");
    pix_valid = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cv_base = cv_cnt;

    // frame E (pattern A) over stale RAM contents of frame D
    px(0, 0, 1'b1, 1'b0);
    for (int x = 1; x < 8; x++) px(x, 0, 1'b0, 1'b0);
    rows(1, 5, 1'b0);
    px(0, 6, 1'b0, 1'b0);
    check("e_no_early_cv", cv_cnt, cv_base);
    check("e_r6_refresh", int'(refresh), 1);
    px(1, 6, 1'b0, 1'b0);
    check("e_r6x0_cv", int'(col_valid), 1);
    chk_col("e_r6x0", 0, 6, 1'b0);
    bub();
    bub();
    check("e_tail_cv", int'(col_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
